// File: rtl/mux_arbiter4_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
// Holds the FSM encoding, requester sizing and the reset value of the rotation pointer.
package mux_arbiter4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Pointer starts at 3 so requester 0 is searched first after reset.
  localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_arbiter4_rr_pick4.sv
// Combinational rotating picker: searches last+1 .. last+4 (mod 4) over the unmasked requests.
// Returns the first asserted candidate, or found=0 when none is pending.
module rr_pick4
  import mux_arbiter4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] c;

  always_comb begin
    cand  = req & ~mask;
    found = 1'b0;
    idx   = last;
    c     = last;
    for (int k = 1; k <= N_REQ; k++) begin
      c = last + IDX_W'(k);
      if (!found && cand[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter4.sv
// Round-robin arbiter and sequencer driving the select and active-low enable of a 4-to-1 mux.
// Bounds each tenure to MAX_HOLD cycles under contention and hands off without a bubble.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no owner; grant=0, enable=1, signal keeps its last value
//   ST_GRANT | owner = last_q drives the mux; hold counter tracks tenure
module mux_arbiter4
  import mux_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] signal,
  output logic             enable,
  output logic             busy,
  output logic [CNT_W-1:0] holdCnt
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] signal_q, signal_d;
  logic             enable_q, enable_d;

  logic [N_REQ-1:0] pick_mask;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // While granted, the owner is excluded so handoff/preempt always names someone else.
  assign pick_mask = (state_q == ST_GRANT) ? onehot(last_q) : '0;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    signal_d   = signal_q;
    enable_d   = enable_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          last_d     = pick_idx;
          hold_cnt_d = '0;
          grant_d    = onehot(pick_idx);
          signal_d   = pick_idx;
          enable_d   = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!req[last_q] || (hold_cnt_q == HOLD_LIM)) begin
          if (pick_found) begin
            last_d     = pick_idx;
            hold_cnt_d = '0;
            grant_d    = onehot(pick_idx);
            signal_d   = pick_idx;
            enable_d   = 1'b0;
          end else if (!req[last_q]) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
            grant_d    = '0;
            enable_d   = 1'b1;
          end
          // else: uncontested at the limit, owner keeps the line and the count saturates
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        enable_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_RST;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      signal_q   <= '0;
      enable_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      signal_q   <= signal_d;
      enable_q   <= enable_d;
    end
  end

  assign grant   = grant_q;
  assign signal  = signal_q;
  assign enable  = enable_q;
  assign busy    = (state_q == ST_GRANT);
  assign holdCnt = hold_cnt_q;

endmodule

// File: doc/mux_arbiter4.md
# mux_arbiter4

Round-robin arbiter and sequencer for the team's 4-to-1 multiplexer: four requesters compete for the shared output line `y`, and this block drives the mux's 2-bit `signal` select and its active-low `enable`. The block bounds each tenure with a hold limit and hands the line directly from one requester to the next without a bubble. It sits between the requesting units and `mux4To1`. It is the only driver of the mux control pins.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps the line while another requester is waiting. Legal range is 1..255.
- `CNT_W`, default 8: width of the hold counter. It must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `req` input, 4 bits: `req[i]` = requester i wants the line; it is held high for the whole transfer.
- `grant` output, 4 bits: one-hot owner, or all-zero when idle. Registered.
- `signal` output, 2 bits: mux select, equal to the owner index. Registered.
- `enable` output, 1 bit: mux enable, active-low. `enable` = 0 exactly when `grant` != 0. Registered.
- `busy` output, 1 bit: high while in GRANT.
- `holdCnt` output, CNT_W bits: cycles the current owner has held the line, minus 1. Debug/verification visibility.

## Operation
- Reset values:
  - outputs: `grant`=4'b0000, `signal`=2'b00, `enable`=1, `busy`=0, `holdCnt`=0
  - internal: `last` pointer = 3, so requester 0 has first priority.
- Priority rule: rotating. Candidates are searched in order `last`+1, `last`+2, `last`+3, `last`+4, all mod 4. The first asserted candidate wins.
- States:
  - IDLE:
    - outputs: `grant`=0, `enable`=1, `signal` holds its previous value.
    - if `req`!=0: grant the winner, load `last`=winner, clear `holdCnt`, go to GRANT.
  - GRANT, with owner o = `last`:
    - Owner release (`req[o]`=0):
      - if another request is pending, grant the rotating winner at the same edge (direct handoff) and clear `holdCnt`;
      - otherwise go to IDLE.
    - Preempt: `req[o]`=1, `holdCnt`=MAX_HOLD-1 and another request is pending. The next rotating winner (o excluded) takes the line at that edge and `holdCnt` is cleared.
    - Saturate: `req[o]`=1, `holdCnt`=MAX_HOLD-1 and no other request. The owner keeps the line and `holdCnt` stays at MAX_HOLD-1.
    - Otherwise the owner keeps the line and `holdCnt` increments.
- `MAX_HOLD`=1: under contention, ownership rotates every cycle.
- Requests from non-owners never change `grant` mid-tenure, except at a preempt edge.
- A requester that drops `req` before it is granted is simply skipped. No request is latched.
- `reset` high in any state forces the reset values at that edge. This includes mid-tenure.

## Timing
- Grant latency: `req[i]` rising and sampled at edge N → `grant[i]`, `signal`, `enable`=0 valid after edge N, i.e. for all of cycle N+1.
- Release: `req[o]` falling and sampled at edge N → the new owner, or IDLE (`enable`=1), is valid after edge N. There is no dead cycle on handoff.
- Preempt: an owner granted at edge G loses the line at edge G+MAX_HOLD if contention exists at that edge. The owner therefore holds exactly MAX_HOLD cycles.
- `grant`, `signal` and `enable` change only together, on the same edge. They are never inconsistent, so there is no glitch on the mux select path.

## Structure
- The shared package holds:
  - the state encoding (IDLE=1'b0, GRANT=1'b1);
  - `N_REQ`=4 and `IDX_W`=2;
  - the reset value of `last` (2'd3).
- One sub-module is natural: `rr_pick4`. It is combinational and has these ports:
  - inputs: `req[3:0]`, `last[1:0]`, `mask[3:0]`;
  - outputs: `found`, `idx[1:0]`.
- The top level contains the FSM, `holdCnt` and the output registers. `rr_pick4` is instantiated once. Its mask input excludes the owner for handoff and preempt decisions.

## Test plan
- Reset, then `req`=4'b0000 for 5 cycles: `grant`=0, `enable`=1, `signal`=0 and `busy`=0 throughout.
- `req`=4'b0100 at edge 2: after edge 2, `grant`=4'b0100, `signal`=2, `enable`=0. Drop `req` at edge 6: after edge 6, `grant`=0, `enable`=1.
- MAX_HOLD=4, `req`=4'b1111 held: `grant` sequence is 0001, 1000, 0100 … no, rotating order 0001→0010→0100→1000→0001. Each owner holds exactly 4 cycles, and `holdCnt` goes 0,1,2,3 per tenure.
- Owner 1 is granted, then `req`=4'b0010 held alone for 20 cycles: `grant` stays 4'b0010, `holdCnt` saturates at MAX_HOLD-1 and there is no preempt.
- Owner 0 holds the line with `req[3]` pending; `req[0]` drops at edge N: after edge N, `grant`=4'b1000 and `signal`=3. There is no IDLE cycle.
- `reset` asserted mid-tenure while owner 2 holds the line: after that edge, all outputs take their reset values. With `req`=4'b1111 afterwards, the first grant is 4'b0001.
